// File: rtl/relu_argmax_stage.sv
// ReLU + row-argmax stage: captures a BxM matrix in one beat and streams it out
// element by element in row-major order with a running per-row argmax.
module relu_argmax_stage #(
    parameter  int B     = 2,
    parameter  int M     = 3,
    parameter  int WIDTH = 32,
    parameter  int FRAC  = 16,
    localparam int CW_B  = $clog2((B > 2) ? B : 2),
    localparam int CW_M  = $clog2((M > 2) ? M : 2)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [B-1:0][M-1:0][WIDTH-1:0]  in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic signed [WIDTH-1:0]         out_data,
    output logic [CW_B-1:0]                 out_row,
    output logic [CW_M-1:0]                 out_col,
    output logic                            out_last_col,
    output logic                            out_last,
    output logic [CW_M-1:0]                 out_class
);

    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("relu_argmax_stage: FRAC must lie in [0, WIDTH)");
    end

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                           r_state;
    state_t                           w_state_next;
    logic                             r_alive;
    logic [B-1:0][M-1:0][WIDTH-1:0]   r_buf;
    logic [B-1:0][M-1:0][WIDTH-1:0]   w_relu;
    logic [CW_B-1:0]                  r_row;
    logic [CW_M-1:0]                  r_col;
    logic [WIDTH-1:0]                 r_max_val;
    logic [CW_M-1:0]                  r_max_idx;
    logic [WIDTH-1:0]                 w_cur;
    logic                             w_capture;
    logic                             w_beat;
    logic                             w_at_last_col;
    logic                             w_at_last;
    logic                             w_take;

    // Negative words (including the most negative one) clamp to zero.
    for (genvar gi = 0; gi < B; gi++) begin : g_relu_row
        for (genvar gj = 0; gj < M; gj++) begin : g_relu_col
            assign w_relu[gi][gj] = in_data[gi][gj][WIDTH-1] ? '0 : in_data[gi][gj];
        end
    end

    assign w_cur         = r_buf[r_row][r_col];
    assign w_at_last_col = (r_col == CW_M'(M - 1));
    assign w_at_last     = w_at_last_col && (r_row == CW_B'(B - 1));
    // Strictly-greater keeps the earliest index on ties; col 0 always seeds the row.
    assign w_take        = (r_col == '0) || (w_cur > r_max_val);
    assign w_capture     = in_valid && in_ready;
    assign w_beat        = out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = r_alive;
                if (in_valid && r_alive) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                if (out_ready && w_at_last) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_alive   <= 1'b0;
            r_buf     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
        end else begin
            r_state <= w_state_next;
            r_alive <= 1'b1;
            if (w_capture) begin
                r_buf     <= w_relu;
                r_row     <= '0;
                r_col     <= '0;
                r_max_val <= '0;
                r_max_idx <= '0;
            end else if (w_beat) begin
                if (w_at_last_col) begin
                    r_col     <= '0;
                    r_row     <= w_at_last ? '0 : r_row + 1'b1;
                    r_max_val <= '0;
                    r_max_idx <= '0;
                end else begin
                    r_col <= r_col + 1'b1;
                    if (w_take) begin
                        r_max_val <= w_cur;
                        r_max_idx <= r_col;
                    end
                end
            end
        end
    end

    assign out_data     = w_cur;
    assign out_row      = r_row;
    assign out_col      = r_col;
    assign out_last_col = out_valid && w_at_last_col;
    assign out_last     = out_valid && w_at_last;
    assign out_class    = w_take ? r_col : r_max_idx;

endmodule
